// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the two-port mem8k arbiter: memory geometry,
//   timeout counter width and the transaction FSM state encoding.
//   No ports (package).
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 16;

   // Wide enough for any timeout setting in the supported 1..255 range.
   localparam int TMO_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   One requester's handshake bundle toward the arbiter.
//   req/we/addr/wdata : requester -> arbiter (held stable until ack)
//   ack/err/rdata     : arbiter -> requester (one-cycle completion pulse)
//   modport master : the requester side
//   modport slave  : the arbiter side
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
   import mem_arbiter_pkg::*;

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic              err;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  ack, err, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output ack, err, rdata
   );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin picker with a last-grant pointer.
//   clk, rst : clock and asynchronous active-low reset
//   req[1:0] : request vector (bit N = port N)
//   update   : accept the current pick (moves the last-grant pointer)
//   valid    : at least one request present
//   pick     : chosen port id
// -----------------------------------------------------------------------------
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   output logic       valid,
   output logic       pick
);

   logic last;

   // With a single requester it simply wins; when both ask, the port that
   // did not get the previous grant wins so neither can starve the other.
   always_comb begin
      valid = |req;
      pick  = req[1];
      if (req == 2'b11) begin
         pick = ~last;
      end
   end

   // The pointer starts at port 1 so that a simultaneous first request goes
   // to port 0; it only moves when the owner actually accepts a grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last <= 1'b1;
      end else if (update) begin
         last <= pick;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single-port 8K x 16 mem8k between an instruction-fetch port
//   (p0) and a data load/store port (p1). Round-robin, one transaction in
//   flight, IDLE -> ISSUE -> WAIT -> RESP. A missing done is turned into an
//   error response after TIMEOUT_CYC WAIT cycles. All outputs are registered.
//   clk, rst         : clock, asynchronous active-low reset
//   p0, p1           : requester bundles (slave side)
//   mem_read/write   : one-cycle strobes to mem8k
//   mem_*_addr       : latched word address
//   mem_wr_data      : latched write data
//   mem_rd_data      : memory read data, valid with mem_rd_done
//   mem_rd/wr_done   : memory completion
//   busy             : FSM not in IDLE
//   grant_id         : owner of the current or last transaction
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYC = 15
) (
   input  logic              clk,
   input  logic              rst,
   mem_arbiter_if.slave      p0,
   mem_arbiter_if.slave      p1,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_read_addr,
   output logic [ADDR_W-1:0] mem_write_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data,
   input  logic              mem_rd_done,
   input  logic              mem_wr_done,
   output logic              busy,
   output logic              grant_id
);

   localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(TIMEOUT_CYC - 1);

   arb_state_t        state, state_n;
   logic [TMO_W-1:0]  cnt, cnt_n;
   logic              we_q, we_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [DATA_W-1:0] wdata_q, wdata_n;
   logic              gid_q, gid_n;
   logic              rd_q, rd_n;
   logic              wr_q, wr_n;
   logic              busy_q, busy_n;
   logic [1:0]        ack_q, ack_n;
   logic [1:0]        err_q, err_n;
   logic [DATA_W-1:0] rdata0_q, rdata0_n;
   logic [DATA_W-1:0] rdata1_q, rdata1_n;
   logic              match_done;
   logic [DATA_W-1:0] rdata_sel;
   logic              pick_valid;
   logic              pick_id;
   logic              take;

   rr_arb2 u_rr (
      .clk    (clk),
      .rst    (rst),
      .req    ({p1.req, p0.req}),
      .update (take),
      .valid  (pick_valid),
      .pick   (pick_id)
   );

   // Next-state and next-output logic. Every output is computed here one
   // cycle ahead and registered below, so strobes, acks and busy line up with
   // the state they belong to. The transaction fields are captured only on
   // the IDLE->ISSUE step and then held until the next grant, which keeps the
   // memory address/data stable from ISSUE through RESP. In WAIT only the
   // done that matches the direction counts; a done seen in ISSUE is never
   // looked at because ISSUE always moves straight on.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      we_n       = we_q;
      addr_n     = addr_q;
      wdata_n    = wdata_q;
      gid_n      = gid_q;
      rd_n       = 1'b0;
      wr_n       = 1'b0;
      ack_n      = 2'b00;
      err_n      = 2'b00;
      rdata0_n   = '0;
      rdata1_n   = '0;
      take       = 1'b0;
      match_done = 1'b0;
      rdata_sel  = '0;

      case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               take    = 1'b1;
               gid_n   = pick_id;
               we_n    = pick_id ? p1.we    : p0.we;
               addr_n  = pick_id ? p1.addr  : p0.addr;
               wdata_n = pick_id ? p1.wdata : p0.wdata;
               rd_n    = ~we_n;
               wr_n    = we_n;
               state_n = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            cnt_n   = '0;
            state_n = ST_WAIT;
         end

         ST_WAIT: begin
            match_done = we_q ? mem_wr_done : mem_rd_done;
            if (match_done || (cnt == CNT_LAST)) begin
               state_n       = ST_RESP;
               ack_n[gid_q]  = 1'b1;
               err_n[gid_q]  = ~match_done;
               if (match_done && !we_q) begin
                  rdata_sel = mem_rd_data;
               end
               if (gid_q) begin
                  rdata1_n = rdata_sel;
               end else begin
                  rdata0_n = rdata_sel;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         ST_RESP: begin
            state_n = ST_IDLE;
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase

      busy_n = (state_n != ST_IDLE);
   end

   // State and output registers. Reset is asynchronous so an in-flight
   // transaction is abandoned at once: strobes, acks and busy fall without
   // waiting for a clock, and no response is ever produced for it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         gid_q    <= 1'b0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         busy_q   <= 1'b0;
         ack_q    <= 2'b00;
         err_q    <= 2'b00;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         we_q     <= we_n;
         addr_q   <= addr_n;
         wdata_q  <= wdata_n;
         gid_q    <= gid_n;
         rd_q     <= rd_n;
         wr_q     <= wr_n;
         busy_q   <= busy_n;
         ack_q    <= ack_n;
         err_q    <= err_n;
         rdata0_q <= rdata0_n;
         rdata1_q <= rdata1_n;
      end
   end

   // Both memory address outputs carry the one latched transaction address.
   assign mem_read       = rd_q;
   assign mem_write      = wr_q;
   assign mem_read_addr  = addr_q;
   assign mem_write_addr = addr_q;
   assign mem_wr_data    = wdata_q;
   assign busy           = busy_q;
   assign grant_id       = gid_q;

   assign p0.ack   = ack_q[0];
   assign p0.err   = err_q[0];
   assign p0.rdata = rdata0_q;
   assign p1.ack   = ack_q[1];
   assign p1.err   = err_q[1];
   assign p1.rdata = rdata1_q;

endmodule
